cpu_dbg_ctrl: RTL and testbench
===============================

Name: cpu_dbg_ctrl

Overview:
Run/halt/step sequencer and memory-dump scheduler for the single-cycle CPU core.
- Drives the core's clock-enable and the `debug` mux select.
- Halts the core on a PC breakpoint, supports single-step, and resumes.
- While halted, walks `addr` over a requested range of DM, IM or RF and streams the read data out through a valid/ready handshake.
- Sits between the board command/UART front end and the core's debug port.

Parameters:
- AW, 32, width of `pc`, `bp_addr`, `dump_base`, `addr`.
- DW, 32, width of read data.
- LEN_W, 16, width of dump length.
- RD_LAT, 1, cycles from `addr` change to valid `rd_data`; legal range 0..3.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- cmd_run, in, 1, pulse: run continuously.
- cmd_step, in, 1, pulse: execute exactly one instruction.
- cmd_halt, in, 1, pulse: stop the core.
- cmd_dump, in, 1, pulse: start a dump (accepted only when halted).
- bp_en, in, 1, breakpoint enable.
- bp_addr, in, AW, breakpoint PC.
- pc, in, AW, core's current PC.
- dump_sel, in, 2, dump target: 0=DM, 1=IM, 2=RF, 3=reserved (command ignored).
- dump_base, in, AW, first dump address (word index).
- dump_len, in, LEN_W, number of words; 0 = no-op.
- rd_data, in, DW, mux of dout_dm/dout_im/dout_rf selected by `mem_sel`.
- dump_ready, in, 1, consumer accepts the current word.
- cpu_en, out, 1, core clock enable.
- debug, out, 1, 1 = debug port owns `addr`.
- addr, out, AW, debug read address.
- mem_sel, out, 2, registered copy of `dump_sel`.
- dump_data, out, DW, word being offered.
- dump_valid, out, 1, `dump_data` is valid.
- dump_done, out, 1, one-cycle pulse after the last word is accepted.
- halted, out, 1, core is stopped.
- bp_hit, out, 1, sticky: halted by breakpoint; cleared on run/step.
- cyc_cnt, out, 32, count of enabled core cycles (see optional feature).

Behaviour:
- States: HALT, RUN, STEP, DADDR, DWAIT, DOUT.
- Reset:
  - State = HALT; `cpu_en`=0, `debug`=0, `addr`=0, `mem_sel`=0, `dump_valid`=0, `dump_done`=0, `bp_hit`=0, `cyc_cnt`=0.
  - `halted`=1.
  - `dump_data`=0.
- `cpu_en` is combinational from state and the breakpoint compare:
  - RUN: `cpu_en` = !(bp_en && pc==bp_addr && !skip_bp).
  - STEP: `cpu_en`=1 for exactly one cycle.
  - All other states: `cpu_en`=0.
- `skip_bp` is set on entry to RUN and cleared after the first RUN cycle. Resuming from a breakpoint therefore executes the instruction at `bp_addr` once.
- HALT:
  - `cmd_run` → RUN; clears `bp_hit`.
  - `cmd_step` → STEP; clears `bp_hit`.
  - `cmd_dump` with sel≠3 and len≠0 → DADDR: latch `mem_sel`=`dump_sel`, counter=len, `addr`=`dump_base`, `debug`=1.
  - `cmd_dump` with len=0 → stay in HALT, pulse `dump_done` next cycle.
  - Priority when pulses coincide: halt > step > run > dump.
- RUN:
  - On breakpoint match (skip_bp=0) → HALT, set `bp_hit`. `cpu_en` is already 0 in the match cycle, so the instruction at `bp_addr` is not executed.
  - `cmd_halt` → HALT. `cpu_en`=0 in the same cycle as the halt pulse.
  - `cmd_run`/`cmd_step`/`cmd_dump` are ignored.
- STEP: one enabled cycle, then → HALT. Breakpoint is ignored in STEP.
- DADDR → DWAIT. Wait RD_LAT cycles (RD_LAT=0 skips DWAIT), then capture `rd_data` into `dump_data` and → DOUT.
- DOUT:
  - Hold `dump_valid`=1 and `dump_data` stable until `dump_ready`.
  - On accept: counter-1, `addr`+1.
  - If counter was 1 → HALT, `debug`=0, `dump_done`=1 for one cycle. Otherwise → DADDR.
  - `addr` wraps modulo 2^AW with no error.
- `cmd_halt` during a dump aborts it: → HALT next cycle, `dump_valid`=0, `debug`=0, no `dump_done`.
- `halted` = (state != RUN && state != STEP).
- Synchronous `rst` in any state returns all outputs to reset values on the next edge. A partial dump is discarded.

Optional Feature:
- CPU_DBG_CYCCNT_EN defined: `cyc_cnt` increments on each cycle with `cpu_en`=1, wraps at 2^32, and clears on `rst` or `cmd_run`.
- Not defined: `cyc_cnt` is tied to 0 and no counter register is built.

Test Plan:
- Breakpoint: reset, bp_en=1, bp_addr=0xC4, `cmd_run`, PC model advancing +4 per enabled cycle → `halted`=1 and `bp_hit`=1 with `pc`=0xC4. `cpu_en` is 0 in the match cycle.
- Resume: from the 0xC4 breakpoint, `cmd_run` → exactly one enabled cycle at pc=0xC4, pc advances to 0xC8, core keeps running; a later `cmd_halt` gives `cpu_en`=0 in the same cycle.
- Step: halted at pc=0x10, three `cmd_step` pulses spaced apart → exactly 3 enabled cycles, pc=0x1C, `halted`=1 after each.
- Dump with backpressure: RD_LAT=1, sel=DM, base=0x5, len=4, `dump_ready` toggled 1/0 → data words 5..8 in order, each held while ready=0, `dump_done` after the 4th accept, `debug` back to 0.
- Edge cases: len=0 → `dump_done` only, `dump_valid` never asserted; `cmd_halt` mid-dump → abort, no `dump_done`; `rst` mid-RUN → `cpu_en`=0, `halted`=1 next edge.
- CPU_DBG_CYCCNT_EN defined: 10 enabled cycles → `cyc_cnt`=10. Without the macro, `cyc_cnt` stays 0.

Source files
------------

// File: rtl/cpu_dbg_ctrl.sv
// Run/halt/step sequencer and memory-dump scheduler for the single-cycle core's debug port.
// Optional feature: define CPU_DBG_CYCCNT_EN to build the enabled-cycle counter on cyc_cnt.
module cpu_dbg_ctrl #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic             cmd_dump,
  input  logic             bp_en,
  input  logic [AW-1:0]    bp_addr,
  input  logic [AW-1:0]    pc,
  input  logic [1:0]       dump_sel,
  input  logic [AW-1:0]    dump_base,
  input  logic [LEN_W-1:0] dump_len,
  input  logic [DW-1:0]    rd_data,
  input  logic             dump_ready,
  output logic             cpu_en,
  output logic             debug,
  output logic [AW-1:0]    addr,
  output logic [1:0]       mem_sel,
  output logic [DW-1:0]    dump_data,
  output logic             dump_valid,
  output logic             dump_done,
  output logic             halted,
  output logic             bp_hit,
  output logic [31:0]      cyc_cnt
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  typedef enum logic [2:0] {
    S_HALT, S_RUN, S_STEP, S_DADDR, S_DWAIT, S_DOUT
  } state_t;

  state_t           state, state_nx;
  logic             skip_bp;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       wait_cnt;

  logic bp_match, enter_run, clr_bp, set_bp;
  logic start_dump, zero_dump, capture, accept;

  // skip_bp lets a resume execute the instruction sitting on the breakpoint once.
  assign bp_match = bp_en && (pc == bp_addr) && !skip_bp;

  always_comb begin
    state_nx   = state;
    cpu_en     = 1'b0;
    enter_run  = 1'b0;
    clr_bp     = 1'b0;
    set_bp     = 1'b0;
    start_dump = 1'b0;
    zero_dump  = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      S_HALT: begin
        if (cmd_halt) begin
          state_nx = S_HALT;
        end else if (cmd_step) begin
          state_nx = S_STEP;
          clr_bp   = 1'b1;
        end else if (cmd_run) begin
          state_nx  = S_RUN;
          clr_bp    = 1'b1;
          enter_run = 1'b1;
        end else if (cmd_dump && dump_sel != 2'd3) begin
          if (dump_len == '0) begin
            zero_dump = 1'b1;
          end else begin
            start_dump = 1'b1;
            state_nx   = S_DADDR;
          end
        end
      end
      S_RUN: begin
        cpu_en = !bp_match && !cmd_halt;
        if (cmd_halt) begin
          state_nx = S_HALT;
        end else if (bp_match) begin
          state_nx = S_HALT;
          set_bp   = 1'b1;
        end
      end
      S_STEP: begin
        cpu_en   = 1'b1;
        state_nx = S_HALT;
      end
      S_DADDR: begin
        if (cmd_halt) begin
          state_nx = S_HALT;
        end else if (LAT == 2'd0) begin
          capture  = 1'b1;
          state_nx = S_DOUT;
        end else begin
          state_nx = S_DWAIT;
        end
      end
      S_DWAIT: begin
        if (cmd_halt) begin
          state_nx = S_HALT;
        end else if (wait_cnt >= LAT) begin
          capture  = 1'b1;
          state_nx = S_DOUT;
        end
      end
      S_DOUT: begin
        if (cmd_halt) begin
          state_nx = S_HALT;
        end else if (dump_ready) begin
          accept   = 1'b1;
          state_nx = (cnt == LEN_W'(1)) ? S_HALT : S_DADDR;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HALT;
      skip_bp   <= 1'b0;
      cnt       <= '0;
      wait_cnt  <= '0;
      addr      <= '0;
      mem_sel   <= '0;
      dump_data <= '0;
      dump_done <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      state     <= state_nx;
      dump_done <= zero_dump || (accept && cnt == LEN_W'(1));
      if (enter_run)
        skip_bp <= 1'b1;
      else if (state == S_RUN)
        skip_bp <= 1'b0;
      if (clr_bp)
        bp_hit <= 1'b0;
      else if (set_bp)
        bp_hit <= 1'b1;
      if (start_dump) begin
        mem_sel <= dump_sel;
        cnt     <= dump_len;
        addr    <= dump_base;
      end
      // wait_cnt counts cycles since addr last changed; DADDR is cycle 0.
      if (state == S_DADDR)
        wait_cnt <= 2'd1;
      else if (state == S_DWAIT)
        wait_cnt <= wait_cnt + 2'd1;
      if (capture)
        dump_data <= rd_data;
      if (accept) begin
        cnt  <= cnt - LEN_W'(1);
        addr <= addr + AW'(1);
      end
    end
  end

  assign dump_valid = (state == S_DOUT);
  assign debug      = (state == S_DADDR) || (state == S_DWAIT) || (state == S_DOUT);
  assign halted     = (state != S_RUN) && (state != S_STEP);

`ifdef CPU_DBG_CYCCNT_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst || cmd_run)
      cyc_q <= '0;
    else if (cpu_en)
      cyc_q <= cyc_q + 32'd1;
  end
  assign cyc_cnt = cyc_q;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_dbg_ctrl.sv
// Bench for cpu_dbg_ctrl: PC/memory environment, command drivers, dump scoreboard, summary.
module tb_cpu_dbg_ctrl;
  localparam int AW = 32, DW = 32, LEN_W = 16, RD_LAT = 1;
`ifdef CPU_DBG_CYCCNT_EN
  localparam bit CYC_ON = 1'b1;
`else
  localparam bit CYC_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             cmd_run, cmd_step, cmd_halt, cmd_dump, bp_en;
  logic [AW-1:0]    bp_addr, pc, dump_base;
  logic [1:0]       dump_sel;
  logic [LEN_W-1:0] dump_len;
  logic [DW-1:0]    rd_data;
  logic             dump_ready = 1'b0;
  logic             cpu_en, debug, dump_valid, dump_done, halted, bp_hit;
  logic [AW-1:0]    addr;
  logic [1:0]       mem_sel;
  logic [DW-1:0]    dump_data;
  logic [31:0]      cyc_cnt;

  cpu_dbg_ctrl #(.AW(AW), .DW(DW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .cmd_dump(cmd_dump), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .dump_sel(dump_sel),
    .dump_base(dump_base), .dump_len(dump_len), .rd_data(rd_data), .dump_ready(dump_ready),
    .cpu_en(cpu_en), .debug(debug), .addr(addr), .mem_sel(mem_sel), .dump_data(dump_data),
    .dump_valid(dump_valid), .dump_done(dump_done), .halted(halted), .bp_hit(bp_hit),
    .cyc_cnt(cyc_cnt)
  );

  // reference memories: each target holds a distinct function of its address
  function automatic logic [31:0] word_of(input logic [1:0] sel, input logic [31:0] a);
    case (sel)
      2'd0:    return a;
      2'd1:    return a ^ 32'hA5A5_0000;
      default: return a + 32'h1000_0000;
    endcase
  endfunction

  // environment: PC advances by 4 per enabled cycle, memory answers one cycle after addr
  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;
  logic        en_s = 1'b0;
  logic [31:0] a_s = 32'h0;
  logic [1:0]  s_s = 2'd0;
  always @(negedge clk) begin
    en_s = cpu_en;
    a_s  = addr;
    s_s  = mem_sel;
  end
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (en_s) pc <= pc + 32'd4;
    rd_data <= word_of(s_s, a_s);
  end

  // consumer backpressure: 0 = always ready, 1 = toggle, 2 = random
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dump_ready = 1'b1;
      1:       dump_ready = ~dump_ready;
      default: dump_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard
  int checks = 0, errors = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] e;
  int en_cnt = 0, acc_cnt = 0, done_cnt = 0, valid_cyc = 0;
  logic done_due = 1'b0, hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_en) begin
        en_cnt++;
        chk("en_while_halted", 32'(halted), 32'd0);
      end
      if (dump_valid) valid_cyc++;
      if (dump_done) done_cnt++;
      if (done_due) chk("dump_done_timing", 32'(dump_done), 32'd1);
      done_due = 1'b0;
      if (hold_v && dump_valid) chk("hold_data", dump_data, hold_d);
      hold_v = dump_valid && !dump_ready;
      hold_d = dump_data;
      if (dump_valid && dump_ready && !cmd_halt) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("dump_data", dump_data, e[DW-1:0]);
          if (e[DW]) done_due = 1'b1;
        end
      end
    end
  end

  // drivers (all entered and left at posedge + 1)
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: cmd_run = 1'b1;
      1: cmd_step = 1'b1;
      2: cmd_halt = 1'b1;
      default: cmd_dump = 1'b1;
    endcase
    cyc(1);
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; cmd_dump = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_load_val = v;
    pc_load = 1'b1;
    cyc(1);
    pc_load = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int k = 0;
    while (!halted && k < budget) begin cyc(1); k++; end
    chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic start_dump(input logic [1:0] sel, input logic [31:0] base, input int len);
    if (sel != 2'd3)
      for (int j = 0; j < len; j++)
        exp_q.push_back({(j == len - 1), word_of(sel, base + 32'(j))});
    dump_sel = sel; dump_base = base; dump_len = LEN_W'(len);
    pulse(3);
  endtask

  task automatic wait_dump_end(input int budget);
    int k = 0;
    while (debug && k < budget) begin cyc(1); k++; end
    chk("dump_timeout", 32'(debug), 32'd0);
    cyc(2);
  endtask

  int en0, d0, a0, v0, k;

  initial begin
    cmd_run = 0; cmd_step = 0; cmd_halt = 0; cmd_dump = 0;
    bp_en = 0; bp_addr = 0; dump_sel = 0; dump_base = 0; dump_len = 0;
    rst = 1'b1; pc_load_val = 32'hB0; pc_load = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; pc_load = 1'b0;
    chk("rst_cpu_en", 32'(cpu_en), 0);      chk("rst_debug", 32'(debug), 0);
    chk("rst_addr", addr, 0);               chk("rst_mem_sel", 32'(mem_sel), 0);
    chk("rst_valid", 32'(dump_valid), 0);   chk("rst_done", 32'(dump_done), 0);
    chk("rst_halted", 32'(halted), 1);      chk("rst_bp_hit", 32'(bp_hit), 0);
    chk("rst_cyc_cnt", cyc_cnt, 0);         chk("rst_dump_data", dump_data, 0);

    // breakpoint at 0xC4 starting from 0xB0: five instructions execute
    bp_en = 1'b1; bp_addr = 32'hC4; en0 = en_cnt;
    pulse(0);
    wait_halted(50);
    chk("bp_hit", 32'(bp_hit), 1);
    chk("bp_pc", pc, 32'hC4);
    chk("bp_en_cycles", en_cnt - en0, 5);
    chk("bp_cyc_cnt", cyc_cnt, CYC_ON ? 32'd5 : 32'd0);

    // resume steps over the breakpoint and keeps running
    en0 = en_cnt;
    pulse(0);
    cyc(4);
    chk("resume_running", 32'(halted), 0);
    chk("resume_bp_clr", 32'(bp_hit), 0);
    chk("resume_en_cycles", en_cnt - en0, 4);
    chk("resume_pc", pc, 32'hD4);
    cmd_halt = 1'b1;
    #1 chk("halt_same_cycle_en", 32'(cpu_en), 0);
    cyc(1); cmd_halt = 1'b0;
    chk("halt_halted", 32'(halted), 1);

    // three single steps from 0x10; breakpoint at 0x14 is ignored while stepping
    bp_addr = 32'h14;
    load_pc(32'h10);
    en0 = en_cnt;
    for (int i = 0; i < 3; i++) begin
      pulse(1);
      cyc(3);
      chk("step_halted", 32'(halted), 1);
      chk("step_pc", pc, 32'h10 + 32'(4 * (i + 1)));
    end
    chk("step_en_cycles", en_cnt - en0, 3);
    bp_en = 1'b0;

    // dump DM 5..8 with toggling ready
    ready_mode = 1; d0 = done_cnt; a0 = acc_cnt;
    start_dump(2'd0, 32'h5, 4);
    wait_dump_end(200);
    chk("bp_dump_done", done_cnt - d0, 1);
    chk("bp_dump_accepts", acc_cnt - a0, 4);
    chk("bp_dump_q_empty", exp_q.size(), 0);

    // zero length: done only; reserved select: nothing
    d0 = done_cnt; v0 = valid_cyc;
    start_dump(2'd1, 32'h77, 0);
    cyc(3);
    chk("len0_done", done_cnt - d0, 1);
    chk("len0_no_valid", valid_cyc - v0, 0);
    d0 = done_cnt;
    start_dump(2'd3, 32'h0, 4);
    cyc(4);
    chk("sel3_no_done", done_cnt - d0, 0);
    chk("sel3_no_valid", valid_cyc - v0, 0);
    chk("sel3_debug", 32'(debug), 0);

    // random dumps, first one wraps the address space
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      start_dump(2'($urandom_range(0, 2)), (i == 0) ? 32'hFFFF_FFFE : $urandom(),
                 $urandom_range(1, 5));
      wait_dump_end(300);
      chk("rnd_dump_done", done_cnt - d0, 1);
      chk("rnd_q_empty", exp_q.size(), 0);
    end

    // abort a dump mid-stream
    d0 = done_cnt; a0 = acc_cnt; k = 0;
    start_dump(2'd2, 32'h40, 8);
    while (acc_cnt - a0 < 2 && k < 200) begin cyc(1); k++; end
    chk("abort_progress_timeout", 32'(acc_cnt - a0 >= 2), 1);
    pulse(2);
    exp_q.delete();
    chk("abort_valid", 32'(dump_valid), 0);
    chk("abort_debug", 32'(debug), 0);
    cyc(3);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_halted", 32'(halted), 1);

    // reset while running
    ready_mode = 0;
    pulse(0);
    cyc(3);
    chk("prerst_running", 32'(halted), 0);
    rst = 1'b1;
    cyc(1);
    chk("rstrun_cpu_en", 32'(cpu_en), 0);
    chk("rstrun_halted", 32'(halted), 1);
    chk("rstrun_cyc_cnt", cyc_cnt, 0);
    rst = 1'b0;

    // ten enabled cycles then breakpoint
    load_pc(32'h200);
    bp_en = 1'b1; bp_addr = 32'h228; en0 = en_cnt;
    pulse(0);
    wait_halted(50);
    chk("cyc10_en_cycles", en_cnt - en0, 10);
    chk("cyc10_cyc_cnt", cyc_cnt, CYC_ON ? 32'd10 : 32'd0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
